// File: rtl/signal_detect_pkg.sv
// Shared encodings for the multi-channel signal presence detector.
//   sd_state_e  : per-channel presence FSM state
//   edge_mode_e : edge_mode input encoding (11 behaves as rising)
//   state_is_present() : presence decode from the FSM state
package signal_detect_pkg;

  typedef enum logic [1:0] {
    StNoSignal   = 2'd0,
    StAcquire    = 2'd1,
    StHaveSignal = 2'd2,
    StLosing     = 2'd3
  } sd_state_e;

  typedef enum logic [1:0] {
    EdgeRise    = 2'b00,
    EdgeFall    = 2'b01,
    EdgeBoth    = 2'b10,
    EdgeRiseAlt = 2'b11
  } edge_mode_e;

  // LOSING still reports presence: loss is only declared once the run completes.
  function automatic logic state_is_present(sd_state_e s);
    return (s == StHaveSignal) || (s == StLosing);
  endfunction

endpackage

// File: rtl/sd_channel.sv
// One detector channel: synchroniser, edge detect, saturating window
// accumulator, presence FSM with run counter.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   enable_i        : 0 clears accumulator/run counter and forces StNoSignal
//   win_end_i       : terminal cycle of the shared measurement window
//   edge_mode_i     : edge select (see edge_mode_e)
//   signal_i        : asynchronous input pin
//   edge_count_o    : count of the last completed window
//   signal_exist_o  : presence flag, decoded from the state flops
//   state_change_o  : one-cycle pulse in the cycle signal_exist_o changes
module sd_channel
  import signal_detect_pkg::*;
#(
  parameter int unsigned CntWidth     = 16,
  parameter int unsigned OnThreshold  = 26,
  parameter int unsigned OffThreshold = 20,
  parameter int unsigned LockWindows  = 2,
  parameter int unsigned LossWindows  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                win_end_i,
  input  logic [1:0]          edge_mode_i,
  input  logic                signal_i,
  output logic [CntWidth-1:0] edge_count_o,
  output logic                signal_exist_o,
  output logic                state_change_o
);

  localparam int unsigned MaxRun = (LockWindows > LossWindows) ? LockWindows : LossWindows;
  localparam int unsigned RunW   = $clog2(MaxRun + 1);
  localparam logic [RunW-1:0] LockRun = RunW'(LockWindows);
  localparam logic [RunW-1:0] LossRun = RunW'(LossWindows);

  logic                sync1_q, sync2_q, hist_q;
  logic                rise, fall, edge_hit;
  logic [CntWidth-1:0] acc_q, acc_next, count_q;
  logic                meets_on, meets_off;
  sd_state_e           state_q;
  logic [RunW-1:0]     run_q;
  logic                exist_dly_q;

  // Two-flop synchroniser plus one history stage for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= signal_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  always_comb begin
    rise     = sync2_q & ~hist_q;
    fall     = ~sync2_q & hist_q;
    edge_hit = rise;
    case (edge_mode_i)
      EdgeFall: edge_hit = fall;
      EdgeBoth: edge_hit = rise | fall;
      default:  edge_hit = rise;
    endcase
  end

  // Saturating increment; also the value latched at window end, so an edge
  // in the terminal cycle still belongs to the closing window.
  assign acc_next  = (edge_hit && !(&acc_q)) ? acc_q + 1'b1 : acc_q;
  // Compare at 32 bits so thresholds above the counter range never truncate.
  assign meets_on  = 32'(acc_next) >= OnThreshold;
  assign meets_off = 32'(acc_next) >= OffThreshold;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      count_q <= '0;
    end else if (!enable_i) begin
      acc_q   <= '0;
    end else if (win_end_i) begin
      count_q <= acc_next;
      acc_q   <= '0;
    end else begin
      acc_q   <= acc_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StNoSignal;
      run_q   <= '0;
    end else if (!enable_i) begin
      state_q <= StNoSignal;
      run_q   <= '0;
    end else if (win_end_i) begin
      case (state_q)
        StNoSignal: begin
          if (meets_on) begin
            if (LockWindows == 1) begin
              state_q <= StHaveSignal;
            end else begin
              state_q <= StAcquire;
              run_q   <= RunW'(1);
            end
          end
        end
        StAcquire: begin
          if (!meets_on) begin
            state_q <= StNoSignal;
            run_q   <= '0;
          end else if (run_q + 1'b1 == LockRun) begin
            state_q <= StHaveSignal;
            run_q   <= '0;
          end else begin
            run_q   <= run_q + 1'b1;
          end
        end
        StHaveSignal: begin
          if (!meets_off) begin
            if (LossWindows == 1) begin
              state_q <= StNoSignal;
            end else begin
              state_q <= StLosing;
              run_q   <= RunW'(1);
            end
          end
        end
        StLosing: begin
          if (meets_off) begin
            state_q <= StHaveSignal;
            run_q   <= '0;
          end else if (run_q + 1'b1 == LossRun) begin
            state_q <= StNoSignal;
            run_q   <= '0;
          end else begin
            run_q   <= run_q + 1'b1;
          end
        end
        default: begin
          state_q <= StNoSignal;
          run_q   <= '0;
        end
      endcase
    end
  end

  // Delayed copy of the presence flag; the XOR pulses exactly in the cycle
  // the flag differs from its previous value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exist_dly_q <= 1'b0;
    end else begin
      exist_dly_q <= signal_exist_o;
    end
  end

  assign signal_exist_o = state_is_present(state_q);
  assign state_change_o = signal_exist_o ^ exist_dly_q;
  assign edge_count_o   = count_q;

endmodule

// File: rtl/multi_signal_detect.sv
// Multi-channel signal presence detector: counts selected edges per channel
// over a shared fixed-length window and tracks presence with hysteresis.
//   clk, rst      : clock, asynchronous active-low reset
//   enable        : run (1) / clear and hold (0)
//   edge_mode     : 00 rising, 01 falling, 10 both, 11 rising
//   signal_in     : asynchronous channel inputs
//   signal_exist  : per-channel presence flag
//   edge_count    : last completed window count, channel n at [n*CNT_WIDTH +: CNT_WIDTH]
//   count_valid   : one-cycle pulse when edge_count updates
//   state_change  : per-channel pulse when signal_exist toggles
module multi_signal_detect
  import signal_detect_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned WINDOW_CNT    = 200,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned ON_THRESHOLD  = 26,
  parameter int unsigned OFF_THRESHOLD = 20,
  parameter int unsigned LOCK_WINDOWS  = 2,
  parameter int unsigned LOSS_WINDOWS  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [1:0]                    edge_mode,
  input  logic [CHANNELS-1:0]           signal_in,
  output logic [CHANNELS-1:0]           signal_exist,
  output logic [CHANNELS*CNT_WIDTH-1:0] edge_count,
  output logic                          count_valid,
  output logic [CHANNELS-1:0]           state_change
);

  localparam int unsigned WinW = $clog2(WINDOW_CNT);
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_CNT - 1);

  logic [WinW-1:0] win_cnt_q, win_cnt_d;
  logic            win_end;
  logic            count_valid_q;

  assign win_end = enable && (win_cnt_q == WinLast);

  always_comb begin
    win_cnt_d = win_cnt_q + 1'b1;
    if (!enable || win_end) begin
      win_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt_q     <= '0;
      count_valid_q <= 1'b0;
    end else begin
      win_cnt_q     <= win_cnt_d;
      count_valid_q <= win_end;
    end
  end

  assign count_valid = count_valid_q;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    sd_channel #(
      .CntWidth    (CNT_WIDTH),
      .OnThreshold (ON_THRESHOLD),
      .OffThreshold(OFF_THRESHOLD),
      .LockWindows (LOCK_WINDOWS),
      .LossWindows (LOSS_WINDOWS)
    ) u_ch (
      .clk_i         (clk),
      .rst_ni        (rst),
      .enable_i      (enable),
      .win_end_i     (win_end),
      .edge_mode_i   (edge_mode),
      .signal_i      (signal_in[n]),
      .edge_count_o  (edge_count[n*CNT_WIDTH +: CNT_WIDTH]),
      .signal_exist_o(signal_exist[n]),
      .state_change_o(state_change[n])
    );
  end

endmodule

// File: tb/tb_multi_signal_detect.sv
// Directed bench for multi_signal_detect: a default instance plus a
// CNT_WIDTH=4 instance share all inputs. A window-level model (true edge
// totals capped at the counter maximum, presence as a streak of qualifying
// windows) is checked every cycle; literal expectations pin key results.
module tb_multi_signal_detect;

  localparam int CH   = 4;
  localparam int WIN  = 200;
  localparam int ON   = 26;
  localparam int OFF  = 20;
  localparam int LOCK = 2;
  localparam int LOSS = 2;
  localparam int W0   = 16;
  localparam int W1   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [1:0]       edge_mode;
  logic [CH-1:0]    signal_in;
  logic [CH-1:0]    exist0, sc0, exist1, sc1;
  logic [CH*W0-1:0] ec0;
  logic [CH*W1-1:0] ec1;
  logic             cv0, cv1;

  int n_vec  = 0;
  int n_fail = 0;

  multi_signal_detect #(.CHANNELS(CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .edge_mode   (edge_mode),
    .signal_in   (signal_in),
    .signal_exist(exist0),
    .edge_count  (ec0),
    .count_valid (cv0),
    .state_change(sc0)
  );

  multi_signal_detect #(.CHANNELS(CH), .CNT_WIDTH(W1)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .edge_mode   (edge_mode),
    .signal_in   (signal_in),
    .signal_exist(exist1),
    .edge_count  (ec1),
    .count_valid (cv1),
    .state_change(sc1)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  bit          pin_d1 [CH];
  bit          pin_d2 [CH];
  bit          pin_d3 [CH];
  int unsigned raw    [CH];
  int unsigned pos;
  int unsigned ec_m   [2][CH];
  bit          pres_m [2][CH];
  bit          sc_m   [2][CH];
  int unsigned streak [2][CH];
  bit          cv_m;
  int unsigned cap    [2] = '{65535, 15};

  function automatic void model_reset();
    pos  = 0;
    cv_m = 0;
    for (int c = 0; c < CH; c++) begin
      pin_d1[c] = 0; pin_d2[c] = 0; pin_d3[c] = 0; raw[c] = 0;
      for (int i = 0; i < 2; i++) begin
        ec_m[i][c] = 0; pres_m[i][c] = 0; sc_m[i][c] = 0; streak[i][c] = 0;
      end
    end
  endfunction

  function automatic void window_verdict(int i, int c, int unsigned cnt);
    bit old = pres_m[i][c];
    if (!old) begin
      streak[i][c] = (cnt >= ON) ? streak[i][c] + 1 : 0;
      if (streak[i][c] >= LOCK) begin pres_m[i][c] = 1; streak[i][c] = 0; end
    end else begin
      streak[i][c] = (cnt < OFF) ? streak[i][c] + 1 : 0;
      if (streak[i][c] >= LOSS) begin pres_m[i][c] = 0; streak[i][c] = 0; end
    end
    sc_m[i][c] = (pres_m[i][c] != old);
  endfunction

  function automatic void model_step();
    bit          ed [CH];
    bit          rise, fall;
    int unsigned total, cnt;
    // A pin level becomes visible to edge detection after the 3-stage delay.
    for (int c = 0; c < CH; c++) begin
      rise = pin_d2[c] && !pin_d3[c];
      fall = !pin_d2[c] && pin_d3[c];
      case (edge_mode)
        2'b01:   ed[c] = fall;
        2'b10:   ed[c] = rise || fall;
        default: ed[c] = rise;
      endcase
      pin_d3[c] = pin_d2[c]; pin_d2[c] = pin_d1[c]; pin_d1[c] = signal_in[c];
      for (int i = 0; i < 2; i++) sc_m[i][c] = 0;
    end
    if (!enable) begin
      pos = 0; cv_m = 0;
      for (int c = 0; c < CH; c++) begin
        raw[c] = 0;
        for (int i = 0; i < 2; i++) begin
          sc_m[i][c] = pres_m[i][c]; pres_m[i][c] = 0; streak[i][c] = 0;
        end
      end
    end else if (pos == WIN - 1) begin
      pos = 0; cv_m = 1;
      for (int c = 0; c < CH; c++) begin
        total = raw[c] + (ed[c] ? 1 : 0);
        raw[c] = 0;
        for (int i = 0; i < 2; i++) begin
          cnt = (total > cap[i]) ? cap[i] : total;
          ec_m[i][c] = cnt;
          window_verdict(i, c, cnt);
        end
      end
    end else begin
      pos++; cv_m = 0;
      for (int c = 0; c < CH; c++) raw[c] += ed[c] ? 1 : 0;
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input int act, input int a, input int b);
    n_vec++;
    if (act != a && act != b) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d or %0d at %0t", name, act, a, b, $time);
    end
  endtask

  int sc_cnt0 = 0;
  int hi_cnt0 = 0;

  task automatic compare_all();
    logic [CH-1:0]    x0, x1, s0, s1;
    logic [CH*W0-1:0] e0;
    logic [CH*W1-1:0] e1;
    for (int c = 0; c < CH; c++) begin
      x0[c] = pres_m[0][c]; x1[c] = pres_m[1][c];
      s0[c] = sc_m[0][c];   s1[c] = sc_m[1][c];
      e0[c*W0 +: W0] = W0'(ec_m[0][c]);
      e1[c*W1 +: W1] = W1'(ec_m[1][c]);
    end
    chk("cyc_exist", exist0, x0);
    chk("cyc_change", sc0, s0);
    chk("cyc_count", ec0, e0);
    chk("cyc_valid", cv0, cv_m);
    chk("cyc_exist_w4", exist1, x1);
    chk("cyc_change_w4", sc1, s1);
    chk("cyc_count_w4", ec1, e1);
    chk("cyc_valid_w4", cv1, cv_m);
    sc_cnt0 += sc0[0] ? 1 : 0;
    hi_cnt0 += exist0[0] ? 1 : 0;
  endtask

  initial forever begin
    @(negedge clk);
    compare_all();
  end

  // ---------------- stimulus ----------------
  function automatic bit pulse_at(int n, int c);
    int step;
    if (n == 0) return 1'b0;
    step = WIN / n;
    return (c % step == 0) && (c / step < n);
  endfunction

  // n0 / n2 one-cycle pulses spread over a window on channels 0 and 2.
  task automatic drive(input int n0, input int n2, input int len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      signal_in    = '0;
      signal_in[0] = pulse_at(n0, c);
      signal_in[2] = pulse_at(n2, c);
    end
  endtask

  int sc_base, hi_base;

  initial begin
    rst = 1'b1; enable = 1'b0; edge_mode = 2'b00; signal_in = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_exist", exist0, 0);
    chk("reset_count", ec0, 0);
    chk("reset_valid", cv0, 0);
    @(posedge clk); #1 rst = 1'b1; enable = 1'b1;

    // Lock on ch0 at 33 rising edges per window.
    drive(33, 0, WIN);
    @(negedge clk);
    chk2("w1_count_ch0", int'(ec0[15:0]), 33, 34);
    chk("w1_exist", exist0, 4'b0000);
    drive(33, 0, WIN);
    @(negedge clk);
    chk("w2_exist", exist0, 4'b0001);
    chk("w2_change", sc0, 4'b0001);
    chk("w2_idle_counts", ec0[63:16], 0);
    chk("w2_count_w4", ec1[3:0], 15);

    // Hysteresis: 23/window holds, 18/window loses after two windows.
    drive(23, 30, WIN);
    drive(23, 30, WIN);
    @(negedge clk);
    chk("hold23_count", ec0[15:0], 23);
    chk("hold23_exist", exist0, 4'b0101);
    drive(18, 30, WIN);
    @(negedge clk);
    chk("lose1_exist", exist0, 4'b0101);
    drive(18, 30, WIN);
    @(negedge clk);
    chk("lose2_exist", exist0, 4'b0100);
    chk("lose2_change", sc0, 4'b0001);

    // Both-edge mode doubles the count.
    edge_mode = 2'b10;
    drive(14, 0, WIN);
    drive(14, 0, WIN);
    @(negedge clk);
    chk("both_count", ec0[15:0], 28);
    chk("both_exist", exist0, 4'b0001);
    chk("both_change", sc0, 4'b0101);
    edge_mode = 2'b00;
    drive(14, 0, WIN);
    drive(14, 0, WIN);
    drive(14, 0, WIN);
    @(negedge clk);
    chk("rise_count", ec0[15:0], 14);
    chk("rise_exist", exist0, 4'b0000);

    // Acquire abort.
    sc_base = sc_cnt0; hi_base = hi_cnt0;
    drive(30, 0, WIN);
    drive(10, 0, WIN);
    @(negedge clk);
    chk("abort_count", ec0[15:0], 10);
    chk("abort_no_change", sc_cnt0 - sc_base, 0);
    chk("abort_never_high", hi_cnt0 - hi_base, 0);

    // Asynchronous reset mid-window while locked.
    drive(30, 0, WIN);
    drive(30, 0, WIN);
    drive(30, 0, 100);
    #2 rst = 1'b0;
    #1;
    chk("arst_exist", exist0, 0);
    chk("arst_count", ec0, 0);
    chk("arst_valid", cv0, 0);
    chk("arst_change", sc0, 0);
    chk("arst_count_w4", ec1, 0);
    signal_in = '0;
    @(posedge clk); #1 rst = 1'b1;

    // Relock, then disable.
    drive(30, 0, WIN);
    drive(30, 0, WIN);
    @(negedge clk);
    chk("relock_exist", exist0, 4'b0001);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_exist", exist0, 0);
    chk("dis_change", sc0, 4'b0001);
    chk("dis_count", ec0[15:0], 30);
    drive(30, 0, 50);
    signal_in = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("dis_hold_count", ec0[15:0], 30);
    chk("dis_valid", cv0, 0);

    // Saturation of the 4-bit counter at 100 edges/window.
    @(posedge clk); #1 enable = 1'b1;
    drive(100, 0, WIN);
    @(negedge clk);
    chk("sat1_count", ec0[15:0], 99);
    chk("sat1_count_w4", ec1[3:0], 15);
    drive(100, 0, WIN);
    @(negedge clk);
    chk("sat2_count", ec0[15:0], 100);
    chk("sat2_count_w4", ec1[3:0], 15);
    chk("sat2_exist_w4", exist1, 0);
    chk("sat2_exist", exist0, 4'b0001);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
